// File: rtl/i2c_register_target_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  // state     | meaning
  // IDLE      | bus free          ADDR      | shifting address byte
  // ADDR_ACK  | ACK on address    PTR       | shifting pointer byte
  // PTR_ACK   | ACK on pointer    WDATA     | shifting write byte
  // WDATA_ACK | ACK on write      RDATA     | shifting read byte out
  // RDATA_ACK | controller ACK    IGNORE    | not addressed, wait START/STOP
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } i2cTargetState_t;

  localparam logic [6:0] I2C_GENERAL_CALL_ADDR = 7'h00;
  localparam logic [7:0] I2C_GC_RESET_CMD      = 8'h06;

endpackage

// File: rtl/i2c_register_target_if.sv
// I2C pad-side signals; SDA is open drain, so sdaOut = 1 releases the line.
interface i2c_register_target_if;
  logic sclIn;
  logic sdaIn;
  logic sdaOut;

  modport master (output sclIn, output sdaIn, input sdaOut);
  modport slave  (input sclIn, input sdaIn, output sdaOut);
endinterface

// File: rtl/i2c_register_target_line_filter.sv
// Pad synchronizer plus counter glitch filter; emits one-cycle rise/fall pulses.
module i2c_line_filter #(
  parameter int FILTER_DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_DEPTH + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Idle bus is high, so every stage resets to 1 to avoid a false START.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pad};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_DEPTH - 1)) begin
        cnt_q <= '0;
        level <= sync_q[1];
        rise  <= sync_q[1];
        fall  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_register_target.sv
// I2C target exposing a byte-addressed register bank with an auto-incrementing pointer.
// Optional general-call bank reset: define I2C_TARGET_GENERAL_CALL_EN.
module i2c_register_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS      = 7'h50,
  parameter int         REG_COUNT    = 16,
  parameter int         FILTER_DEPTH = 3,
  localparam int        IW           = $clog2(REG_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  i2c_register_target_if.slave  bus,
  input  logic [IW-1:0]         localIndex,
  output logic [7:0]            localData,
  output logic                  wrStrobe,
  output logic [IW-1:0]         wrIndex,
  output logic [7:0]            wrData,
  output logic                  busy
);

  i2cTargetState_t state_q, state_d;

  logic          scl_level, scl_rise, scl_fall;
  logic          sda_level, sda_rise, sda_fall;
  logic [7:0]    bank_q [REG_COUNT];
  logic [IW-1:0] ptr_q;
  logic [7:0]    shift_q;
  logic [3:0]    bit_cnt_q;
  logic          sda_out_q, gc_q, gc_hit;
  logic          start_det, stop_det, byte_done, addr_hit;
  logic          shift_in, wr_fire, ptr_load, rd_load, wr_advance, gc_clear, sda_d;
  logic [7:0]    rx_byte;

  i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_filter (
    .clock(clock), .reset(reset), .pad(bus.sclIn),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_filter (
    .clock(clock), .reset(reset), .pad(bus.sdaIn),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det  = sda_fall & scl_level;
  assign stop_det   = sda_rise & scl_level;
  assign byte_done  = (bit_cnt_q == 4'd8);
  assign rx_byte    = {shift_q[6:0], sda_level};
  assign addr_hit   = (shift_q[7:1] == ADDRESS) || gc_hit;
  assign localData  = bank_q[localIndex];
  assign bus.sdaOut = sda_out_q;

`ifdef I2C_TARGET_GENERAL_CALL_EN
  assign gc_hit = (shift_q[7:1] == I2C_GENERAL_CALL_ADDR) && !shift_q[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                      gc_q <= 1'b0;
    else if (start_det)                             gc_q <= 1'b0;
    else if (state_q == ADDR && scl_fall && byte_done) gc_q <= gc_hit;
  end
`else
  assign gc_hit = 1'b0;
  assign gc_q   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = IDLE;
    end else if (start_det) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:      if (scl_fall && byte_done) state_d = addr_hit ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (scl_fall) state_d = shift_q[0] ? RDATA : PTR;
        PTR:       if (scl_fall && byte_done)
                     state_d = (gc_q && shift_q != I2C_GC_RESET_CMD) ? IGNORE : PTR_ACK;
        PTR_ACK:   if (scl_fall) state_d = gc_q ? IGNORE : WDATA;
        WDATA:     if (scl_fall && byte_done) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall) state_d = WDATA;
        RDATA:     if (scl_fall && byte_done) state_d = RDATA_ACK;
        RDATA_ACK: if (scl_rise && sda_level) state_d = IGNORE;
                   else if (scl_fall)         state_d = RDATA;
        default:   ;
      endcase
    end
  end

  // SDA only moves on a filtered SCL fall, except START/STOP which release it.
  always_comb begin
    shift_in   = 1'b0;
    wr_fire    = 1'b0;
    ptr_load   = 1'b0;
    rd_load    = 1'b0;
    wr_advance = 1'b0;
    gc_clear   = 1'b0;
    sda_d      = sda_out_q;
    if (start_det || stop_det) begin
      sda_d = 1'b1;
    end else begin
      shift_in   = scl_rise && !byte_done && (state_q inside {ADDR, PTR, WDATA});
      wr_fire    = shift_in && state_q == WDATA && bit_cnt_q == 4'd7;
      ptr_load   = shift_in && state_q == PTR && bit_cnt_q == 4'd7 && !gc_q;
      rd_load    = scl_fall && state_d == RDATA && state_q != RDATA;
      wr_advance = scl_fall && state_q == WDATA_ACK;
      gc_clear   = scl_fall && state_q == PTR_ACK && gc_q;
      if (scl_fall) begin
        if ((state_d inside {ADDR_ACK, PTR_ACK, WDATA_ACK}) && state_d != state_q)
          sda_d = 1'b0;
        else if (rd_load)
          sda_d = bank_q[ptr_q][7];
        else if (state_q == RDATA && !byte_done)
          sda_d = shift_q[6];
        else
          sda_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sda_out_q <= 1'b1;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      busy      <= 1'b0;
      wrStrobe  <= 1'b0;
      wrIndex   <= '0;
      wrData    <= '0;
      bank_q    <= '{default: 8'h00};
    end else begin
      sda_out_q <= sda_d;
      wrStrobe  <= wr_fire;
      if (start_det)     busy <= 1'b1;
      else if (stop_det) busy <= 1'b0;

      if (start_det || (scl_fall && state_d != state_q))
        bit_cnt_q <= '0;
      else if (shift_in || (scl_rise && state_q == RDATA && !byte_done))
        bit_cnt_q <= bit_cnt_q + 1'b1;

      if (shift_in)                                       shift_q <= rx_byte;
      else if (rd_load)                                   shift_q <= bank_q[ptr_q];
      else if (scl_fall && state_q == RDATA && !byte_done) shift_q <= {shift_q[6:0], 1'b0};

      if (gc_clear)                   ptr_q <= '0;
      else if (ptr_load)              ptr_q <= rx_byte[IW-1:0];
      else if (rd_load || wr_advance) ptr_q <= ptr_q + 1'b1;

      if (wr_fire) begin
        bank_q[ptr_q] <= rx_byte;
        wrIndex       <= ptr_q;
        wrData        <= rx_byte;
      end
      if (gc_clear) bank_q <= '{default: 8'h00};
    end
  end

endmodule

// File: tb/tb_i2c_register_target.sv
// Bench for i2c_register_target: bit-banged I2C controller plus a register-bank model.
module tb_i2c_register_target;

  localparam int Q = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_ctl = 1'b1;
  logic [3:0] localIndex = '0;
  logic [7:0] localData;
  logic       wrStrobe;
  logic [3:0] wrIndex;
  logic [7:0] wrData;
  logic       busy;

  i2c_register_target_if bus_if ();
  assign bus_if.sclIn = scl;
  assign bus_if.sdaIn = sda_ctl & bus_if.sdaOut;

  i2c_register_target dut (
    .clock(clock), .reset(reset), .bus(bus_if),
    .localIndex(localIndex), .localData(localData),
    .wrStrobe(wrStrobe), .wrIndex(wrIndex), .wrData(wrData), .busy(busy)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mdl_bank [16];
  int          mdl_ptr = 0;
  logic [11:0] strobe_q [$];
  logic [11:0] exp_q [$];

  always @(negedge clock) if (wrStrobe) strobe_q.push_back({wrIndex, wrData});

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_ctl = b; cyc(Q);
    scl = 1'b1;  cyc(Q);
    s = bus_if.sdaIn; cyc(Q);
    scl = 1'b0;  cyc(Q);
  endtask

  task automatic bus_start();
    sda_ctl = 1'b1; cyc(Q);
    scl = 1'b1;     cyc(Q);
    sda_ctl = 1'b0; cyc(Q);
    scl = 1'b0;     cyc(Q);
  endtask

  task automatic bus_stop();
    sda_ctl = 1'b0; cyc(Q);
    scl = 1'b1;     cyc(Q);
    sda_ctl = 1'b1; cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(nack, s);
  endtask

  task automatic check_strobes(input string name);
    check({name, " strobe count"}, strobe_q.size(), exp_q.size());
    while (strobe_q.size() > 0 && exp_q.size() > 0)
      check({name, " strobe"}, int'(strobe_q.pop_front()), int'(exp_q.pop_front()));
    strobe_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] p, input logic [7:0] d [4],
                          input int n, input logic exp_ack, input string name);
    logic ak;
    bus_start();
    check({name, " busy"}, busy, 1);
    send_byte({a, 1'b0}, ak);
    check({name, " addr ack"}, ak, exp_ack);
    if (exp_ack) begin
      send_byte(p, ak);
      check({name, " ptr ack"}, ak, 1);
      mdl_ptr = p % 16;
      for (int i = 0; i < n; i++) begin
        send_byte(d[i], ak);
        check({name, " data ack"}, ak, 1);
        exp_q.push_back({mdl_ptr[3:0], d[i]});
        mdl_bank[mdl_ptr] = d[i];
        mdl_ptr = (mdl_ptr + 1) % 16;
      end
    end
    bus_stop();
    cyc(Q);
    check({name, " idle busy"}, busy, 0);
    check_strobes(name);
  endtask

  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n, input string name);
    logic       ak;
    logic [7:0] got;
    bus_start();
    if (set_ptr) begin
      send_byte(8'hA0, ak);
      check({name, " w addr ack"}, ak, 1);
      send_byte(p, ak);
      check({name, " ptr ack"}, ak, 1);
      mdl_ptr = p % 16;
      bus_start();
    end
    send_byte(8'hA1, ak);
    check({name, " r addr ack"}, ak, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, got);
      check({name, " rd byte"}, got, mdl_bank[mdl_ptr]);
      mdl_ptr = (mdl_ptr + 1) % 16;
    end
    bus_stop();
    cyc(Q);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic [7:0] ptr_b;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    int         i0;
    int         i1;
  } wvec_t;

  wvec_t vt [5];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dv [4];
    logic [7:0] abyte;
    logic       s, ak;
    int         kind, n;

    vt[0] = '{7'h50, 8'h03, 8'hA5, 8'h5A, 1'b1, 3, 4};
    vt[1] = '{7'h50, 8'h0F, 8'h11, 8'h22, 1'b1, 15, 0};
    vt[2] = '{7'h51, 8'h07, 8'h77, 8'h88, 1'b0, 0, 0};
    vt[3] = '{7'h50, 8'h06, 8'hC3, 8'h3C, 1'b1, 6, 7};
    vt[4] = '{7'h50, 8'hFF, 8'h33, 8'h44, 1'b1, 15, 0};
    for (int i = 0; i < 16; i++) mdl_bank[i] = 8'h00;

    cyc(3);
    check("reset sdaOut", bus_if.sdaOut, 1);
    check("reset busy", busy, 0);
    check("reset wrStrobe", wrStrobe, 0);
    check("reset localData", localData, 0);
    reset = 1'b0;
    cyc(10);
    check("post-reset sdaOut", bus_if.sdaOut, 1);

    for (int k = 0; k < 5; k++) begin
      dv = '{vt[k].d0, vt[k].d1, 8'h00, 8'h00};
      do_write(vt[k].addr, vt[k].ptr_b, dv, 2, vt[k].exp_ack, $sformatf("vec%0d", k));
      if (vt[k].exp_ack) begin
        localIndex = vt[k].i0[3:0]; #1;
        check($sformatf("vec%0d localData i0", k), localData, vt[k].d0);
        localIndex = vt[k].i1[3:0]; #1;
        check($sformatf("vec%0d localData i1", k), localData, vt[k].d1);
      end
    end

    do_read(1'b1, 8'h03, 3, "rd_sr");
    do_read(1'b0, 8'h00, 1, "rd_cont");

    sda_ctl = 1'b0; cyc(1); sda_ctl = 1'b1; cyc(20);
    check("sda glitch busy", busy, 0);
    scl = 1'b0; cyc(2); scl = 1'b1; cyc(20);
    check("scl glitch idle busy", busy, 0);

    bus_start();
    send_byte(8'hA0, ak);
    check("glitch addr ack", ak, 1);
    sda_ctl = 1'b1; cyc(Q); scl = 1'b1; cyc(2); scl = 1'b0; cyc(Q);
    send_byte(8'h02, ak);
    check("glitch ptr ack", ak, 1);
    send_byte(8'h99, ak);
    check("glitch data ack", ak, 1);
    mdl_bank[2] = 8'h99; mdl_ptr = 3;
    exp_q.push_back({4'h2, 8'h99});
    bus_stop();
    cyc(Q);
    check_strobes("glitch");

    bus_start();
    abyte = 8'hA0;
    for (int i = 7; i >= 0; i--) bus_bit(abyte[i], s);
    sda_ctl = 1'b1; cyc(Q); scl = 1'b1; cyc(Q / 2);
    check("rst ack driven", bus_if.sdaOut, 0);
    #2 reset = 1'b1;
    #1 check("rst sda release", bus_if.sdaOut, 1);
    for (int i = 0; i < 16; i++) mdl_bank[i] = 8'h00;
    mdl_ptr = 0;
    localIndex = 4'd3; #1;
    check("rst bank", localData, mdl_bank[3]);
    check("rst busy", busy, 0);
    cyc(3); reset = 1'b0; cyc(30);
    check("rst exit busy", busy, 0);
    do_read(1'b0, 8'h00, 1, "rst_rd");

`ifdef I2C_TARGET_GENERAL_CALL_EN
    dv = '{8'h5C, 8'hC5, 8'h00, 8'h00};
    do_write(7'h50, 8'h0F, dv, 2, 1'b1, "gc_pre");
    bus_start();
    send_byte(8'h00, ak);
    check("gc addr ack", ak, 1);
    send_byte(8'h06, ak);
    check("gc cmd ack", ak, 1);
    bus_stop();
    cyc(Q);
    for (int i = 0; i < 16; i++) mdl_bank[i] = 8'h00;
    mdl_ptr = 0;
    localIndex = 4'd15; #1;
    check("gc bank15", localData, mdl_bank[15]);
    localIndex = 4'd0; #1;
    check("gc bank0", localData, mdl_bank[0]);
`else
    bus_start();
    send_byte(8'h00, ak);
    check("gc nack", ak, 0);
    bus_stop();
    cyc(Q);
    check_strobes("gc_off");
`endif

    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 4);
      if (kind <= 1) begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
        do_write(7'h50, 8'($urandom), dv, n, 1'b1, "rnd_wr");
      end else if (kind <= 3) begin
        do_read(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 3), "rnd_rd");
      end else begin
        for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
        do_write(7'h51 + 7'($urandom_range(0, 40)), 8'($urandom), dv, 2, 1'b0, "rnd_miss");
      end
    end

    for (int i = 0; i < 16; i++) begin
      localIndex = i[3:0]; #1;
      check($sformatf("final bank[%0d]", i), localData, mdl_bank[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
